// File: rtl/xbus_responder.sv
// ---------------------------------------------------------------------------
// xbus_responder
//
// Wishbone-b4 pipelined responder for the processor-external bus. It decodes
// one address window starting at BASE_ADDR, serves 32-bit word reads and
// byte-selectable writes from an internal word memory after LATENCY wait
// states, and answers illegal accesses with a bus error.
//
// Parameters
//   BASE_ADDR  window base, aligned to 4*MEM_WORDS
//   MEM_WORDS  memory depth in 32-bit words (power of two, 4..4096)
//   LATENCY    wait states before the response (0..15)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   xbus_adr_i   byte address
//   xbus_dat_i   write data
//   xbus_tag_i   access tag: [0] privileged, [1] nonsecure, [2] instr fetch
//   xbus_we_i    1 = write
//   xbus_sel_i   byte enables, bit n selects bits 8n+7:8n
//   xbus_stb_i   request strobe, one-cycle pulse per access
//   xbus_cyc_i   cycle valid, held from stb until the response
//   xbus_dat_o   read data, non-zero only during a read ack
//   xbus_ack_o   successful completion pulse
//   xbus_err_o   error completion pulse
//   busy_o       access accepted and not yet completed or aborted
//   err_cnt_o    saturating count of error responses
//
// All outputs are registered from the FSM state, so the ack/err pulse and
// busy_o trail the internal state by one clock: the response pulse is seen
// in the cycle after the RESP state, and a new strobe can be accepted at the
// edge that ends that response cycle.
// ---------------------------------------------------------------------------
module xbus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] xbus_adr_i,
  input  logic [31:0] xbus_dat_i,
  input  logic [2:0]  xbus_tag_i,
  input  logic        xbus_we_i,
  input  logic [3:0]  xbus_sel_i,
  input  logic        xbus_stb_i,
  input  logic        xbus_cyc_i,
  output logic [31:0] xbus_dat_o,
  output logic        xbus_ack_o,
  output logic        xbus_err_o,
  output logic        busy_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          bad_q;

  logic [31:0]   mem [MEM_WORDS];

  // Address decode. The window is aligned to its own size, so "inside the
  // window" is simply the upper address bits matching the base.
  logic in_window;
  logic bad_access;
  logic commit;
  logic mem_we;
  logic unused_tag;

  assign in_window  = (xbus_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign bad_access = !in_window
                   || (xbus_adr_i[1:0] != 2'b00)
                   || (xbus_we_i && xbus_tag_i[2]);
  // Privilege and security tag bits do not affect this target.
  assign unused_tag = ^xbus_tag_i[1:0];

  // The access completes at the edge leaving RESP, unless the initiator has
  // dropped cyc, in which case it is silently abandoned.
  assign commit = (state == RESP) && xbus_cyc_i;
  assign mem_we = commit && we_q && !bad_q;

  // NOTE: the memory array is deliberately left out of reset; clearing every
  // word would force it into flops instead of RAM. Reset still prevents
  // stray writes because it holds the FSM in IDLE, which keeps mem_we low.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
        end
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      idx_q      <= '0;
      wdat_q     <= 32'd0;
      sel_q      <= 4'd0;
      we_q       <= 1'b0;
      bad_q      <= 1'b0;
      xbus_dat_o <= 32'd0;
      xbus_ack_o <= 1'b0;
      xbus_err_o <= 1'b0;
      busy_o     <= 1'b0;
      err_cnt_o  <= 16'd0;
    end else begin
      // Response outputs are single-cycle pulses by default.
      xbus_ack_o <= 1'b0;
      xbus_err_o <= 1'b0;
      xbus_dat_o <= 32'd0;

      case (state)
        IDLE: begin
          busy_o <= 1'b0;
          if (xbus_stb_i && xbus_cyc_i) begin
            idx_q  <= xbus_adr_i[AW+1:2];
            wdat_q <= xbus_dat_i;
            sel_q  <= xbus_sel_i;
            we_q   <= xbus_we_i;
            bad_q  <= bad_access;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              wait_cnt <= WAIT_INIT;
              state    <= WAIT;
            end
          end
        end

        WAIT: begin
          if (!xbus_cyc_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            busy_o <= 1'b1;
            if (wait_cnt == 4'd0) begin
              state <= RESP;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end
        end

        RESP: begin
          state  <= IDLE;
          busy_o <= commit;
          if (commit) begin
            if (bad_q) begin
              xbus_err_o <= 1'b1;
              if (err_cnt_o != 16'hFFFF) begin
                err_cnt_o <= err_cnt_o + 16'd1;
              end
            end else begin
              xbus_ack_o <= 1'b1;
              // Reads return the whole word; write acks carry no data.
              if (!we_q) begin
                xbus_dat_o <= mem[idx_q];
              end
            end
          end
        end

        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_responder.sv
// ---------------------------------------------------------------------------
// tb_xbus_responder
//
// Drives three responders (LATENCY 0, 1 and 4) from one shared bus, each with
// its own strobe, and compares every response against a reference model of
// the window rules, a word-array memory image and per-instance error counts.
// ---------------------------------------------------------------------------
module tb_xbus_responder;

  localparam logic [31:0] BASE  = 32'h9000_0000;
  localparam int          WORDS = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [2:0]  tag;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  stb_v;
  logic        cyc;

  logic [31:0] dat_v [3];
  logic [2:0]  ack_v;
  logic [2:0]  err_v;
  logic [2:0]  busy_v;
  logic [15:0] cnt_v [3];

  xbus_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .LATENCY(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .xbus_adr_i(adr), .xbus_dat_i(wdat),
    .xbus_tag_i(tag), .xbus_we_i(we), .xbus_sel_i(sel), .xbus_stb_i(stb_v[0]),
    .xbus_cyc_i(cyc), .xbus_dat_o(dat_v[0]), .xbus_ack_o(ack_v[0]),
    .xbus_err_o(err_v[0]), .busy_o(busy_v[0]), .err_cnt_o(cnt_v[0]));

  xbus_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .xbus_adr_i(adr), .xbus_dat_i(wdat),
    .xbus_tag_i(tag), .xbus_we_i(we), .xbus_sel_i(sel), .xbus_stb_i(stb_v[1]),
    .xbus_cyc_i(cyc), .xbus_dat_o(dat_v[1]), .xbus_ack_o(ack_v[1]),
    .xbus_err_o(err_v[1]), .busy_o(busy_v[1]), .err_cnt_o(cnt_v[1]));

  xbus_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .LATENCY(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .xbus_adr_i(adr), .xbus_dat_i(wdat),
    .xbus_tag_i(tag), .xbus_we_i(we), .xbus_sel_i(sel), .xbus_stb_i(stb_v[2]),
    .xbus_cyc_i(cyc), .xbus_dat_o(dat_v[2]), .xbus_ack_o(ack_v[2]),
    .xbus_err_o(err_v[2]), .busy_o(busy_v[2]), .err_cnt_o(cnt_v[2]));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: memory image, which words hold fully known data, and
  // the expected error count of each instance.
  logic [31:0] mm    [3][WORDS];
  bit          known [3][WORDS];
  logic [15:0] cnt_m [3];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    case (d)
      0:       return 0;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic w, input logic [2:0] t);
    longint la;
    la = longint'(a);
    return (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * WORDS)
        || (a % 4 != 0) || (w && t[2]);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // One complete access on instance d. The caller sits at a falling edge;
  // the strobe is sampled at the next rising edge. With hold set, cyc stays
  // high after the response so the caller can issue the next strobe at once.
  task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] dt,
                      input logic [2:0] t, input logic w, input logic [3:0] s,
                      input bit hold);
    bit          e;
    logic [31:0] exp_dat;
    int          i;
    e       = model_err(a, w, t);
    exp_dat = 32'd0;
    if (!e && !w) exp_dat = mm[d][word_of(a)];
    adr = a; wdat = dt; tag = t; we = w; sel = s;
    stb_v[d] = 1'b1;
    cyc      = 1'b1;
    @(negedge clk);
    stb_v = 3'b000;
    check("resp_early", {30'd0, ack_v[d], err_v[d]}, 32'd0);
    check("busy_accept", {31'd0, busy_v[d]}, 32'd0);
    repeat (lat_of(d)) begin
      @(negedge clk);
      check("resp_in_wait", {30'd0, ack_v[d], err_v[d]}, 32'd0);
      check("busy_wait", {31'd0, busy_v[d]}, 32'd1);
    end
    @(negedge clk);
    check("ack", {31'd0, ack_v[d]}, {31'd0, !e});
    check("err", {31'd0, err_v[d]}, {31'd0, e});
    check("busy_resp", {31'd0, busy_v[d]}, 32'd1);
    if (e || !w) check("dat", dat_v[d], exp_dat);
    if (e) begin
      if (cnt_m[d] != 16'hFFFF) cnt_m[d] = cnt_m[d] + 16'd1;
    end else if (w) begin
      i = word_of(a);
      for (int b = 0; b < 4; b++)
        if (s[b]) mm[d][i][8*b +: 8] = dt[8*b +: 8];
      if (s == 4'hF) known[d][i] = 1'b1;
    end
    check("err_cnt", {16'd0, cnt_v[d]}, {16'd0, cnt_m[d]});
    if (!hold) begin
      cyc = 1'b0;
      @(negedge clk);
      check("idle_after", {29'd0, ack_v[d], err_v[d], busy_v[d]}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    logic [2:0]  rt;
    logic        rw;
    logic [3:0]  rs;
    int          k;
    int          kind;

    rst = 1'b1; cyc = 1'b0; stb_v = 3'b000;
    adr = 32'd0; wdat = 32'd0; tag = 3'd0; we = 1'b0; sel = 4'd0;
    for (int d = 0; d < 3; d++) cnt_m[d] = 16'd0;

    // Reset state of every instance.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_ack",  {31'd0, ack_v[d]},  32'd0);
      check("rst_err",  {31'd0, err_v[d]},  32'd0);
      check("rst_busy", {31'd0, busy_v[d]}, 32'd0);
      check("rst_dat",  dat_v[d], 32'd0);
      check("rst_cnt",  {16'd0, cnt_v[d]},  32'd0);
    end

    // LATENCY=1: full write, read back, partial write, read back.
    xfer(1, 32'h9000_0010, 32'hDEAD_BEEF, 3'b000, 1'b1, 4'hF, 1'b0);
    xfer(1, 32'h9000_0010, 32'h0,         3'b000, 1'b0, 4'hF, 1'b0);
    xfer(1, 32'h9000_0010, 32'h1122_3344, 3'b001, 1'b1, 4'b0101, 1'b0);
    xfer(1, 32'h9000_0010, 32'h0,         3'b000, 1'b0, 4'b0001, 1'b0);
    check("partial_word", dat_v[1] | mm[1][4], 32'hDE22_BE44);

    // Error cases: past the window, misaligned, write as instruction fetch.
    xfer(1, 32'h9000_0400, 32'h0,         3'b000, 1'b0, 4'hF, 1'b0);
    xfer(1, 32'h9000_0002, 32'h0,         3'b000, 1'b0, 4'hF, 1'b0);
    xfer(1, 32'h9000_0010, 32'h5555_AAAA, 3'b100, 1'b1, 4'hF, 1'b0);
    xfer(1, 32'h9000_0010, 32'h0,         3'b000, 1'b0, 4'hF, 1'b0);
    xfer(1, 32'h8FFF_FFFC, 32'h0,         3'b000, 1'b0, 4'hF, 1'b0);
    xfer(1, 32'h9000_03FC, 32'h0,         3'b000, 1'b1, 4'h0, 1'b0);

    // LATENCY=4: abort a write by dropping cyc two cycles after the strobe.
    xfer(2, 32'h9000_0020, 32'hCAFE_F00D, 3'b000, 1'b1, 4'hF, 1'b0);
    xfer(2, 32'h9000_0024, 32'h2424_2424, 3'b000, 1'b1, 4'hF, 1'b0);
    adr = 32'h9000_0020; wdat = 32'h0000_0000; tag = 3'b000; we = 1'b1; sel = 4'hF;
    stb_v[2] = 1'b1; cyc = 1'b1;
    @(negedge clk);
    stb_v = 3'b000;
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy_v[2]}, 32'd1);
    cyc = 1'b0;
    @(negedge clk);
    check("abort_busy_fall", {31'd0, busy_v[2]}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_resp", {30'd0, ack_v[2], err_v[2]}, 32'd0);
    end
    xfer(2, 32'h9000_0020, 32'h0, 3'b000, 1'b0, 4'hF, 1'b0);

    // Reset pulsed during WAIT: outputs clear at once, no late response.
    adr = 32'h9000_0024; wdat = 32'h0BAD_F00D; tag = 3'b000; we = 1'b1; sel = 4'hF;
    stb_v[2] = 1'b1; cyc = 1'b1;
    @(negedge clk);
    stb_v = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("rstw_busy_before", {31'd0, busy_v[2]}, 32'd1);
    rst = 1'b1;
    cyc = 1'b0;
    #1;
    check("rstw_busy", {31'd0, busy_v[2]}, 32'd0);
    check("rstw_resp", {30'd0, ack_v[2], err_v[2]}, 32'd0);
    check("rstw_dat",  dat_v[2], 32'd0);
    check("rstw_cnt",  {16'd0, cnt_v[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) cnt_m[d] = 16'd0;
    repeat (8) begin
      @(negedge clk);
      check("rstw_no_resp", {30'd0, ack_v[2], err_v[2]}, 32'd0);
    end
    xfer(2, 32'h9000_0024, 32'h0, 3'b000, 1'b0, 4'hF, 1'b0);

    // Randomized accesses on every instance against the model.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 30; n++) begin
        kind = $urandom_range(0, 9);
        k    = $urandom_range(0, WORDS - 1);
        case (kind)
          0:       ra = BASE + 32'h400 + 32'(4 * $urandom_range(0, 255));
          1:       ra = BASE - 32'(4 + 4 * $urandom_range(0, 15));
          2:       ra = BASE + 32'(4 * k) + 32'($urandom_range(1, 3));
          default: ra = BASE + 32'(4 * k);
        endcase
        rd = $urandom;
        rw = 1'($urandom_range(0, 1));
        rs = 4'($urandom_range(0, 15));
        rt = {($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3))};
        if (!model_err(ra, rw, rt) && !rw && !known[d][word_of(ra)]) begin
          rw = 1'b1;
          rs = 4'hF;
        end
        xfer(d, ra, rd, rt, rw, rs, 1'b0);
      end
    end

    // LATENCY=0 back-to-back: each strobe issued in the previous ack cycle.
    for (int n = 0; n < 4; n++)
      xfer(0, BASE + 32'(32 * n), 32'hA5A5_0000 + 32'(n), 3'b000, 1'b1, 4'hF, 1'b1);
    for (int n = 0; n < 4; n++)
      xfer(0, BASE + 32'(32 * n), 32'h0, 3'b000, 1'b0, 4'hF, (n != 3));

    // Saturation: preload the counter near its limit, then run errors
    // back-to-back across the top.
    force u_dut0.err_cnt_o = 16'hFFF0;
    #1;
    release u_dut0.err_cnt_o;
    cnt_m[0] = 16'hFFF0;
    @(negedge clk);
    for (int n = 0; n < 20; n++)
      xfer(0, BASE + 32'h400, 32'h0, 3'b000, 1'b0, 4'hF, (n != 19));
    check("sat_final", {16'd0, cnt_v[0]}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
